// File: rtl/cpu_program_loader_pkg.sv
// Shared definitions for the CPU program loader.
//   state_t      : loader FSM states
//   IMEM_WORDS_D : default instruction-memory word count
//   DMEM_WORDS_D : default data-memory word count
//   IMAGE_BYTES  : bytes in a full image (2 per word plus one checksum byte)
package cpu_program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV_HI = 3'd1,
        ST_RECV_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    localparam int IMEM_WORDS_D = 32;
    localparam int DMEM_WORDS_D = 16;
    localparam int IMAGE_BYTES  = 2 * (IMEM_WORDS_D + DMEM_WORDS_D) + 1;

endpackage

// File: rtl/cpu_program_loader_byte_assembler.sv
// Byte assembler for the program loader: latches the high byte of each
// big-endian word and keeps the running 8-bit checksum of every image byte.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   clear       : restart a new image (sum back to 0)
//   hi_en       : current byte is a word's high byte (latch it, add to sum)
//   lo_en       : current byte is a word's low byte (add to sum)
//   byte_in     : byte on the stream this cycle
//   word_next   : {latched high byte, byte_in}, the word completed this cycle
//   sum_next    : running sum plus byte_in, modulo 256
module cpu_program_loader_byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        hi_en,
    input  logic        lo_en,
    input  logic [7:0]  byte_in,
    output logic [15:0] word_next,
    output logic [7:0]  sum_next
);

    logic [7:0] hi_q;
    logic [7:0] sum_q;

    // Combinational look-ahead so the top can register the finished word and
    // judge the checksum byte in the same cycle the byte is accepted.
    assign word_next = {hi_q, byte_in};
    assign sum_next  = sum_q + byte_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q  <= 8'h00;
            sum_q <= 8'h00;
        end else if (clear) begin
            sum_q <= 8'h00;
        end else begin
            if (hi_en) begin
                hi_q  <= byte_in;
            end
            if (hi_en || lo_en) begin
                sum_q <= sum_next;
            end
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Program loader placed in front of the 16-bit CPU. Receives the program
// image as bytes, writes IMEM_WORDS instruction words then DMEM_WORDS data
// words through the CPU load port, then checks a trailing checksum byte.
// The CPU is held in reset until the checksum passes.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is a register (no path from in_valid); the sender must hold
// in_data stable while in_valid is high and not yet accepted.
//
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   start           : begin a load (from IDLE, DONE or ERROR)
//   in_valid/in_data/in_ready : byte stream
//   cpu_input, load_address, load, is_instruction : CPU load port (registered)
//   cpu_reset       : CPU reset, released only after a good image
//   busy/done/error : loader status
module cpu_program_loader
    import cpu_program_loader_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_D,
    parameter int DMEM_WORDS = DMEM_WORDS_D,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] cpu_input,
    output logic [ADDR_W-1:0] load_address,
    output logic              load,
    output logic              is_instruction,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state;
    logic [ADDR_W-1:0] word_cnt;
    logic              phase_instr;

    logic              accept;
    logic              restart;
    logic [15:0]       word_next;
    logic [7:0]        sum_next;

    assign accept  = in_valid && in_ready;
    assign restart = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

    cpu_program_loader_byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .hi_en     (accept && state == ST_RECV_HI),
        .lo_en     (accept && state == ST_RECV_LO),
        .byte_in   (in_data),
        .word_next (word_next),
        .sum_next  (sum_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            word_cnt       <= '0;
            phase_instr    <= 1'b0;
            in_ready       <= 1'b0;
            load           <= 1'b0;
            cpu_input      <= '0;
            load_address   <= '0;
            is_instruction <= 1'b0;
            cpu_reset      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (restart) begin
                        state       <= ST_RECV_HI;
                        word_cnt    <= '0;
                        phase_instr <= 1'b1;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        cpu_reset   <= 1'b1;
                    end
                end
                ST_RECV_HI: begin
                    if (accept) begin
                        state <= ST_RECV_LO;
                    end
                end
                ST_RECV_LO: begin
                    // Register the completed word now so load is high for
                    // exactly the single WRITE cycle.
                    if (accept) begin
                        state          <= ST_WRITE;
                        in_ready       <= 1'b0;
                        load           <= 1'b1;
                        cpu_input      <= DATA_W'(word_next);
                        load_address   <= word_cnt;
                        is_instruction <= phase_instr;
                    end
                end
                ST_WRITE: begin
                    in_ready <= 1'b1;
                    if (phase_instr) begin
                        state <= ST_RECV_HI;
                        if (word_cnt == ADDR_W'(IMEM_WORDS - 1)) begin
                            word_cnt    <= '0;
                            phase_instr <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + ADDR_W'(1);
                        end
                    end else if (word_cnt == ADDR_W'(DMEM_WORDS - 1)) begin
                        state <= ST_CHECK;
                    end else begin
                        state    <= ST_RECV_HI;
                        word_cnt <= word_cnt + ADDR_W'(1);
                    end
                end
                ST_CHECK: begin
                    // Image is good when all bytes including this one sum to 0.
                    if (accept) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (sum_next == 8'h00) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
module tb_cpu_program_loader;

  localparam int IMEM = 32;
  localparam int DMEM = 16;
  localparam int NBYTES = 2 * (IMEM + DMEM) + 1;
  localparam int LIMIT = 3000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] cpu_input;
  logic [4:0]  load_address;
  logic        load;
  logic        is_instruction;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int n_vec;
  int n_err;

  // Image bytes, expected and observed load transfers {is_instr, addr, data}.
  logic [7:0]  img_q[$];
  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];

  cpu_program_loader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .cpu_input      (cpu_input),
    .load_address   (load_address),
    .load           (load),
    .is_instruction (is_instruction),
    .cpu_reset      (cpu_reset),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- load monitor ----------------
  always @(posedge clk) begin
    #1;
    if (load === 1'b1) obs_q.push_back({is_instruction, load_address, cpu_input});
  end

  // ---------------- reference model ----------------
  // Words in CPU order, split big-endian, with a trailing byte that makes
  // the sum of all bytes 0 mod 256 (plus one when a bad image is wanted).
  task automatic build_image(input bit rand_words, input bit bad);
    logic [15:0] w;
    int sum;
    img_q.delete();
    exp_q.delete();
    sum = 0;
    for (int k = 0; k < IMEM + DMEM; k++) begin
      if (rand_words) w = 16'($urandom);
      else if (k < IMEM) w = 16'h1000 + 16'(k);
      else w = 16'hA000 + 16'(k - IMEM);
      img_q.push_back(w[15:8]);
      img_q.push_back(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
      if (k < IMEM) exp_q.push_back({1'b1, 5'(k), w});
      else exp_q.push_back({1'b0, 5'(k - IMEM), w});
    end
    img_q.push_back(8'((256 - (sum % 256)) % 256 + (bad ? 1 : 0)));
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams img_q from a negedge until done/error, or until stop_loads loads
  // were seen. cyc counts rising edges since entry.
  task automatic run_load(input int valid_pct, input int stop_loads,
                          input int pulse_at, output int cyc);
    int idx;
    bit fired;
    bit pulsed;
    idx = 0;
    cyc = 0;
    pulsed = 0;
    while (cyc < LIMIT) begin
      if (done === 1'b1 || error === 1'b1) break;
      if (stop_loads > 0 && obs_q.size() >= stop_loads) break;
      in_valid = (idx < img_q.size()) && ($urandom_range(99) < valid_pct);
      in_data = in_valid ? img_q[idx] : 8'($urandom);
      fired = in_valid && (in_ready === 1'b1);
      start = 1'b0;
      if (pulse_at > 0 && !pulsed && obs_q.size() == pulse_at) begin
        start = 1'b1;
        pulsed = 1;
      end
      @(negedge clk);
      cyc++;
      if (fired) idx++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({in_ready, load, cpu_input, load_address, is_instruction, busy, done, error, cpu_reset}
        !== {1'b0, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b load=%b data=%h addr=%h ins=%b busy=%b done=%b err=%b cpurst=%b, required 0 0 0000 00 0 0 0 0 1",
               in_ready, load, cpu_input, load_address, is_instruction, busy, done, error, cpu_reset);
    end
  endtask

  task automatic test_full_image();
    int cyc;
    build_image(0, 0);
    obs_q.delete();
    pulse_start();
    run_load(100, 0, 0, cyc);
    n_vec++;
    if (cyc !== 145) begin
      n_err++;
      $display("FAIL full_latency: done after %0d cycles, required 145", cyc);
    end
    n_vec++;
    if ({done, error, busy, cpu_reset} !== 4'b1000) begin
      n_err++;
      $display("FAIL full_status: done/err/busy/cpurst=%b, required 1000", {done, error, busy, cpu_reset});
    end
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL full_load_count: %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL full_load[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    // Phase boundary: last instruction, first data, last data word.
    if (obs_q.size() == 48) begin
      n_vec++;
      if (obs_q[31][21:16] !== {1'b1, 5'd31} || obs_q[32][21:16] !== {1'b0, 5'd0}
          || obs_q[47][21:16] !== {1'b0, 5'd15}) begin
        n_err++;
        $display("FAIL boundary_addr: w31=%h w32=%h w47=%h, required 3f 00 0f",
                 obs_q[31][21:16], obs_q[32][21:16], obs_q[47][21:16]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    int cyc;
    build_image(1, 1);
    obs_q.delete();
    pulse_start();
    run_load(100, 0, 0, cyc);
    n_vec++;
    if ({done, error, busy, cpu_reset} !== 4'b0101 || cyc >= LIMIT) begin
      n_err++;
      $display("FAIL bad_status: done/err/busy/cpurst=%b cyc=%0d, required 0101", {done, error, busy, cpu_reset}, cyc);
    end
    n_vec++;
    if (obs_q.size() !== 48) begin
      n_err++;
      $display("FAIL bad_load_count: %0d, required 48", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bad_load[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_in_error();
    int cyc;
    // DUT is in ERROR from the previous test.
    pulse_start();
    n_vec++;
    if ({error, done, busy, cpu_reset, in_ready} !== 5'b00111) begin
      n_err++;
      $display("FAIL error_restart: err/done/busy/cpurst/rdy=%b, required 00111", {error, done, busy, cpu_reset, in_ready});
    end
    build_image(1, 0);
    obs_q.delete();
    run_load(100, 0, 0, cyc);
    n_vec++;
    if ({done, error, cpu_reset} !== 3'b100 || obs_q.size() !== 48) begin
      n_err++;
      $display("FAIL error_reload: done/err/cpurst=%b loads=%0d, required 100 and 48", {done, error, cpu_reset}, obs_q.size());
    end
  endtask

  task automatic test_random_gaps();
    int cyc;
    build_image(0, 0);
    obs_q.delete();
    pulse_start();
    // A start pulse part way through must be ignored.
    run_load(50, 0, 10, cyc);
    n_vec++;
    if ({done, error, cpu_reset} !== 3'b100 || cyc >= LIMIT || cyc < 145) begin
      n_err++;
      $display("FAIL gaps_status: done/err/cpurst=%b cyc=%0d, required 100 in 145..%0d", {done, error, cpu_reset}, cyc, LIMIT - 1);
    end
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL gaps_load_count: %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL gaps_load[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    build_image(1, 0);
    obs_q.delete();
    pulse_start();
    run_load(70, 20, 0, cyc);
    n_vec++;
    if (obs_q.size() !== 20 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL midload_progress: loads=%0d busy=%b, required 20 and 1", obs_q.size(), busy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({in_ready, load, cpu_input, load_address, is_instruction, busy, done, error, cpu_reset}
        !== {1'b0, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midload_reset: rdy=%b load=%b data=%h addr=%h ins=%b busy=%b done=%b err=%b cpurst=%b, required 0 0 0000 00 0 0 0 0 1",
               in_ready, load, cpu_input, load_address, is_instruction, busy, done, error, cpu_reset);
    end
    reset = 1'b1;
    @(negedge clk);
    obs_q.delete();
    pulse_start();
    run_load(100, 0, 0, cyc);
    n_vec++;
    if ({done, error, cpu_reset} !== 3'b100 || cyc !== 145) begin
      n_err++;
      $display("FAIL midload_reload: done/err/cpurst=%b cyc=%0d, required 100 and 145", {done, error, cpu_reset}, cyc);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL midload_load[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_full_image();
    test_bad_checksum();
    test_start_in_error();
    test_random_gaps();
    test_reset_mid_load();
    n_vec++;
    if (img_q.size() !== NBYTES) begin
      n_err++;
      $display("FAIL image_size: %0d, required %0d", img_q.size(), NBYTES);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
Upstream neighbour of the 16-bit CPU. It receives a program image as a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. It drives the CPU's unified load port (cpu_input, load_address, load, is_instruction) to fill instruction memory, then data memory. It holds the CPU in reset while loading and releases it only after the image checksum passes.

Parameters:
IMEM_WORDS, 32, instruction words loaded (addresses 0..IMEM_WORDS-1)
DMEM_WORDS, 16, data words loaded (addresses 0..DMEM_WORDS-1)
ADDR_W, 5, width of load_address
DATA_W, 16, word width (fixed at 2 bytes per word)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte this cycle
cpu_input  output  16  assembled word to CPU
load_address  output  5  target address; data phase uses bits [3:0], bit 4 = 0
load  output  1  one-cycle write strobe to CPU
is_instruction  output  1  1 = instruction memory, 0 = data memory; valid with load
cpu_reset  output  1  active-high reset to CPU; held during load and on error
busy  output  1  load in progress
done  output  1  image loaded, checksum good
error  output  1  checksum mismatch

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; in_ready=0, load=0, cpu_input=0, load_address=0, is_instruction=0, busy=0, done=0, error=0, cpu_reset=1, word counter and checksum accumulator=0.
- Byte accepted only when in_valid && in_ready. in_ready=1 only in RECV_HI, RECV_LO and CHECK. in_ready has no combinational path from in_valid.
- States:
  - IDLE: start -> RECV_HI. Counter=0, phase=instruction, sum=0, busy=1, cpu_reset=1.
  - RECV_HI: on accept, hi byte latched and sum+=byte -> RECV_LO.
  - RECV_LO: on accept, lo byte latched and sum+=byte -> WRITE.
  - WRITE: exactly one cycle with load=1, cpu_input={hi,lo}, load_address=counter, is_instruction=phase. Then:
    - instruction phase, counter<IMEM_WORDS-1: counter+1 -> RECV_HI
    - instruction phase, last word: counter=0, phase=data -> RECV_HI
    - data phase, counter<DMEM_WORDS-1: counter+1 -> RECV_HI
    - data phase, last word -> CHECK
  - CHECK: accept one byte c. If (sum+c) mod 256 == 0 -> DONE, else -> ERROR.
  - DONE: done=1, busy=0, cpu_reset=0.
  - ERROR: error=1, busy=0, cpu_reset=1.
- load, cpu_input, load_address and is_instruction are registered. Outside WRITE, load=0 and the data outputs hold their last value.
- sum is 8-bit and wraps modulo 256.
- Minimum latency: 3 cycles per word. Image = 2*(IMEM_WORDS+DMEM_WORDS)+1 = 97 bytes, 145 cycles minimum from the start cycle to entering DONE.
- start while busy: ignored. start in DONE/ERROR: clears done/error, reasserts cpu_reset, restarts the load.
- Stalls: in_valid=0 in any receive state holds the state indefinitely; no timeout.
- reset==0 mid-load: immediate return to reset values. Partial CPU memory contents are left as is; cpu_reset stays 1.

Decomposition:
- Shared package: state enum (IDLE, RECV_HI, RECV_LO, WRITE, CHECK, DONE, ERROR), IMEM_WORDS/DMEM_WORDS defaults, image byte-count constant.
- One natural sub-module: loader_byte_assembler (hi/lo latch plus running 8-bit checksum). FSM and counter stay in the top module.

Test Plan:
- Full image: instr k = 16'h1000+k, data k = 16'hA000+k, correct checksum, in_valid always 1 -> 48 load pulses with the matching address/is_instruction; done=1 and cpu_reset=0 at cycle 145; CPU output_value matches the program result.
- Bad checksum (correct byte +1) -> error=1, done=0, cpu_reset stays 1; all 48 load pulses still issued.
- Random in_valid gaps (about 50% duty) -> identical load sequence and values as the first test, no extra or dropped load pulses.
- reset=0 asserted after 20 words -> next cycle all outputs at reset values; a fresh start plus full image then ends in done=1.
- start pulsed mid-load and again in ERROR -> mid-load pulse ignored; ERROR pulse restarts, error clears, a good image then reaches done.
- Boundary: word 31 written with is_instruction=1, address 31; next word written with is_instruction=0, address 0; last data word at address 15.
